// File: rtl/seven_to_binary.sv
// rtl/seven_to_binary.sv - debounced active-low seven-segment to hex decoder with ready/valid output
// Optional error counter output ERR_CNT enabled by defining SEV2BIN_ERRCNT_EN.
module seven_to_binary #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] SEV,
    input  logic       SEV_VALID,
    input  logic       BIN_READY,
    output logic [3:0] BIN,
    output logic       BIN_VALID,
    output logic       ERR,
    output logic       BUSY
`ifdef SEV2BIN_ERRCNT_EN
    ,
    output logic [7:0] ERR_CNT
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;
    localparam logic [7:0] STABLE_N = STABLE_CYCLES[7:0];

    logic [1:0] state_q, state_d;
    logic [7:0] count_q, count_d, count_inc;
    logic [6:0] sample_q, sample_d;
    logic [3:0] bin_q, bin_d;
    logic       bin_valid_q, bin_valid_d;
    logic       err_q, err_d;
    logic       busy_q, busy_d;
    logic [4:0] dec_sample, dec_sev;

    // Returns {err, value}; an unmatched pattern decodes to value 0 with err set.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0011000: decode = 5'h09;
            7'b0001000: decode = 5'h0A;
            7'b0000011: decode = 5'h0B;
            7'b1000110: decode = 5'h0C;
            7'b0100001: decode = 5'h0D;
            7'b0000110: decode = 5'h0E;
            7'b0001110: decode = 5'h0F;
            default:    decode = 5'h10;
        endcase
    endfunction

    assign dec_sample = decode(sample_q);
    assign dec_sev    = decode(SEV);
    assign count_inc  = count_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        sample_d    = sample_q;
        bin_d       = bin_q;
        bin_valid_d = bin_valid_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (SEV_VALID) begin
                    sample_d = SEV;
                    count_d  = 8'd1;
                    if (STABLE_N == 8'd1) begin
                        {err_d, bin_d} = dec_sev;
                        bin_valid_d    = 1'b1;
                        state_d        = S_HOLD;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                if (!SEV_VALID) begin
                    count_d = 8'd0;
                    state_d = S_IDLE;
                end else if (SEV == sample_q) begin
                    count_d = count_inc;
                    if (count_inc == STABLE_N) begin
                        {err_d, bin_d} = dec_sample;
                        bin_valid_d    = 1'b1;
                        state_d        = S_HOLD;
                    end
                end else begin
                    sample_d = SEV;
                    count_d  = 8'd1;
                    if (STABLE_N == 8'd1) begin
                        {err_d, bin_d} = dec_sev;
                        bin_valid_d    = 1'b1;
                        state_d        = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (BIN_READY) begin
                    bin_valid_d = 1'b0;
                    count_d     = 8'd0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                count_d     = 8'd0;
                bin_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            count_q     <= 8'd0;
            sample_q    <= 7'h7F;
            bin_q       <= 4'h0;
            bin_valid_q <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            sample_q    <= sample_d;
            bin_q       <= bin_d;
            bin_valid_q <= bin_valid_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign BIN       = bin_q;
    assign BIN_VALID = bin_valid_q;
    assign ERR       = err_q;
    assign BUSY      = busy_q;

`ifdef SEV2BIN_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_q == S_HOLD && BIN_READY && err_q && err_cnt_q != 8'hFF)
            err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) err_cnt_q <= 8'd0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign ERR_CNT = err_cnt_q;
`endif

endmodule
